// File: rtl/instbuffer.sv
// Instruction buffer: circular FIFO between fetch (up to 2 insts/cycle) and decode (show-ahead, up to 2 pops/cycle).
// Optional macro IB_STAT_EN adds saturating empty/full cycle counters.
module instbuffer #(
  parameter int DEPTH         = 16,
  parameter int DECODER_WIDTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic [DECODER_WIDTH-1:0]     i_fetch_valid,
  input  logic [DECODER_WIDTH*32-1:0]  i_fetch_pc,
  input  logic [DECODER_WIDTH*32-1:0]  i_fetch_inst,
  input  logic [DECODER_WIDTH-1:0]     i_fetch_is_branch,
  input  logic [DECODER_WIDTH-1:0]     i_fetch_is_taken,
  input  logic [DECODER_WIDTH*32-1:0]  i_fetch_branch_addr,
  input  logic [DECODER_WIDTH*6-1:0]   i_fetch_is_exception,
  input  logic [DECODER_WIDTH*42-1:0]  i_fetch_exc_cause,
  output logic                         o_buffer_full,
  input  logic [DECODER_WIDTH-1:0]     i_send_inst_en,
  output logic [DECODER_WIDTH-1:0]     o_inst_valid,
  output logic [DECODER_WIDTH*32-1:0]  o_pc,
  output logic [DECODER_WIDTH*32-1:0]  o_inst,
  output logic [DECODER_WIDTH-1:0]     o_pre_is_branch,
  output logic [DECODER_WIDTH-1:0]     o_pre_is_branch_taken,
  output logic [DECODER_WIDTH*32-1:0]  o_pre_branch_addr,
  output logic [DECODER_WIDTH*6-1:0]   o_is_exception,
  output logic [DECODER_WIDTH*42-1:0]  o_exception_cause
`ifdef IB_STAT_EN
  ,
  output logic [31:0]                  o_stat_empty_cycles,
  output logic [31:0]                  o_stat_full_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 32 + 32 + 1 + 1 + 32 + 6 + 42;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_full;

  logic [EW-1:0] w_slot [DECODER_WIDTH];
  logic [EW-1:0] w_rd   [DECODER_WIDTH];
  logic [EW-1:0] w_out  [DECODER_WIDTH];
  logic [EW-1:0] w_wdata0;
  logic [1:0]    w_n_enq;
  logic [1:0]    w_n_deq;
  logic          w_pop0;
  logic          w_pop1;
  logic [PW-1:0] w_tail1;
  logic [PW-1:0] w_head1;
  logic [PW:0]   w_count_next;
  logic          w_full_next;

  genvar gi;
  generate
    for (gi = 0; gi < DECODER_WIDTH; gi++) begin : g_slot
      assign w_slot[gi] = {i_fetch_pc[gi*32 +: 32], i_fetch_inst[gi*32 +: 32],
                           i_fetch_is_branch[gi], i_fetch_is_taken[gi],
                           i_fetch_branch_addr[gi*32 +: 32], i_fetch_is_exception[gi*6 +: 6],
                           i_fetch_exc_cause[gi*42 +: 42]};
      // Invalid slots must read as all-zero, not stale array contents.
      assign w_out[gi] = o_inst_valid[gi] ? w_rd[gi] : '0;
      assign {o_pc[gi*32 +: 32], o_inst[gi*32 +: 32], o_pre_is_branch[gi],
              o_pre_is_branch_taken[gi], o_pre_branch_addr[gi*32 +: 32],
              o_is_exception[gi*6 +: 6], o_exception_cause[gi*42 +: 42]} = w_out[gi];
    end
  endgenerate

  assign w_tail1  = r_tail + PW'(1);
  assign w_head1  = r_head + PW'(1);
  assign w_rd[0]  = r_mem[r_head];
  assign w_rd[1]  = r_mem[w_head1];
  // A lone slot-1 fetch is compacted down to the tail entry.
  assign w_wdata0 = i_fetch_valid[0] ? w_slot[0] : w_slot[1];

  assign o_inst_valid  = {(r_count >= (PW+1)'(2)), (r_count != '0)};
  assign o_buffer_full = r_full;

  assign w_n_enq = r_full ? 2'd0 : ({1'b0, i_fetch_valid[0]} + {1'b0, i_fetch_valid[1]});
  assign w_pop0  = i_send_inst_en[0] & o_inst_valid[0];
  assign w_pop1  = i_send_inst_en[1] & i_send_inst_en[0] & o_inst_valid[1];
  assign w_n_deq = {1'b0, w_pop0} + {1'b0, w_pop1};

  always_comb begin
    w_count_next = r_count + (PW+1)'(w_n_enq) - (PW+1)'(w_n_deq);
    if (i_flush) begin
      w_count_next = '0;
    end
    // Registered full leaves room for a two-wide fetch on the following cycle.
    w_full_next = (w_count_next > (PW+1)'(DEPTH - 2));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && !i_flush && (w_n_enq != 2'd0)) begin
      r_mem[r_tail] <= w_wdata0;
      if (w_n_enq == 2'd2) begin
        r_mem[w_tail1] <= w_slot[1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= w_count_next;
      r_full  <= w_full_next;
    end
  end

`ifdef IB_STAT_EN
  logic [31:0] r_stat_empty;
  logic [31:0] r_stat_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stat_empty <= '0;
      r_stat_full  <= '0;
    end else begin
      if ((r_count == '0) && (r_stat_empty != 32'hFFFF_FFFF)) begin
        r_stat_empty <= r_stat_empty + 32'd1;
      end
      if (r_full && (r_stat_full != 32'hFFFF_FFFF)) begin
        r_stat_full <= r_stat_full + 32'd1;
      end
    end
  end

  assign o_stat_empty_cycles = r_stat_empty;
  assign o_stat_full_cycles  = r_stat_full;
`endif

endmodule
